// File: rtl/md_mem_arbiter.sv
// md_mem_arbiter: sequences main-memory bus cycles feeding the MD register.
// Arbitrates CPU vs spy/debug requests, and the spy is forced through after
// STARVE_MAX consecutive CPU grants. It runs a single-outstanding
// mem_req/mem_ack handshake and returns one-cycle completion pulses. For CPU
// reads it also pulses loadmd.
//
// Optional feature macro: MEM_TIMEOUT_EN. When it is defined, a cycle that
// sees no mem_ack within TIMEOUT clocks is aborted and mem_err pulses. The
// TIMEOUT parameter exists only in that build.
//
// Ports:
//   clk, reset (async, active-low)
//   cpu_req/cpu_wr/cpu_addr : CPU request (level, held until cpu_done)
//   spy_req/spy_wr/spy_addr : spy request (level, held until spy_done)
//   mem_ack                 : bus completion
//   mem_req/mem_wr/mem_addr : registered bus request
//   owner                   : 0 = CPU, 1 = spy
//   loadmd, cpu_done, spy_done, mem_err : registered one-cycle pulses
//   cpu_wait                : combinational CPU stall
module md_mem_arbiter #(
  parameter int unsigned ADDR_W     = 22,
  parameter int unsigned STARVE_MAX = 4
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT    = 255
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              spy_req,
  input  logic              spy_wr,
  input  logic [ADDR_W-1:0] spy_addr,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              owner,
  output logic              loadmd,
  output logic              cpu_done,
  output logic              spy_done,
  output logic              cpu_wait,
  output logic              mem_err
);

  localparam int unsigned STARVE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CYCLE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                mem_req_d, mem_wr_d, owner_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic                loadmd_d, cpu_done_d, spy_done_d, mem_err_d;
  logic                cpu_win, spy_win;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  // Stall the CPU until the cycle that carries its completion pulse.
  assign cpu_wait = cpu_req & ~cpu_done;

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
      mem_req  <= 1'b0;
      mem_wr   <= 1'b0;
      mem_addr <= '0;
      owner    <= 1'b0;
      loadmd   <= 1'b0;
      cpu_done <= 1'b0;
      spy_done <= 1'b0;
      mem_err  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      to_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      mem_req  <= mem_req_d;
      mem_wr   <= mem_wr_d;
      mem_addr <= mem_addr_d;
      owner    <= owner_d;
      loadmd   <= loadmd_d;
      cpu_done <= cpu_done_d;
      spy_done <= spy_done_d;
      mem_err  <= mem_err_d;
`ifdef MEM_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
`endif
    end
  end

  // Arbitration, handshake sequencing and pulse generation.
  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    mem_req_d  = mem_req;
    mem_wr_d   = mem_wr;
    mem_addr_d = mem_addr;
    owner_d    = owner;
    loadmd_d   = 1'b0;
    cpu_done_d = 1'b0;
    spy_done_d = 1'b0;
    mem_err_d  = 1'b0;
`ifdef MEM_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
`endif
    cpu_win = cpu_req & (~spy_req | (starve_q < STARVE_W'(STARVE_MAX)));
    spy_win = spy_req & ~cpu_win;

    case (state_q)
      IDLE: begin
        if (cpu_win) begin
          state_d    = CYCLE;
          mem_req_d  = 1'b1;
          mem_wr_d   = cpu_wr;
          mem_addr_d = cpu_addr;
          owner_d    = 1'b0;
          // The CPU wins against a pending spy only below STARVE_MAX,
          // so the increment saturates at STARVE_MAX by construction.
          starve_d   = spy_req ? starve_q + STARVE_W'(1) : '0;
`ifdef MEM_TIMEOUT_EN
          to_cnt_d   = '0;
`endif
        end else if (spy_win) begin
          state_d    = CYCLE;
          mem_req_d  = 1'b1;
          mem_wr_d   = spy_wr;
          mem_addr_d = spy_addr;
          owner_d    = 1'b1;
          starve_d   = '0;
`ifdef MEM_TIMEOUT_EN
          to_cnt_d   = '0;
`endif
        end
      end
      CYCLE: begin
        if (mem_ack) begin
          state_d    = DONE;
          mem_req_d  = 1'b0;
          loadmd_d   = ~owner & ~mem_wr;
          cpu_done_d = ~owner;
          spy_done_d = owner;
        end
`ifdef MEM_TIMEOUT_EN
        // A timeout abort completes the owner with an error and never loads MD.
        else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d    = DONE;
          mem_req_d  = 1'b0;
          cpu_done_d = ~owner;
          spy_done_d = owner;
          mem_err_d  = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_md_mem_arbiter.sv
// tb_md_mem_arbiter: self-checking bench for md_mem_arbiter.
// Directed scenarios (reset, CPU read/write, starvation order, spy-then-CPU,
// optional timeout) are followed by randomized requesters and acks. All of
// them are compared against a transaction-level reference model.
module tb_md_mem_arbiter;

  localparam int unsigned ADDR_W     = 22;
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned TIMEOUT    = 8;
`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk, reset;
  logic              cpu_req, cpu_wr, spy_req, spy_wr, mem_ack;
  logic [ADDR_W-1:0] cpu_addr, spy_addr, mem_addr;
  logic              mem_req, mem_wr, owner, loadmd, cpu_done, spy_done;
  logic              cpu_wait, mem_err;

  md_mem_arbiter #(
    .ADDR_W(ADDR_W),
    .STARVE_MAX(STARVE_MAX)
`ifdef MEM_TIMEOUT_EN
    ,
    .TIMEOUT(TIMEOUT)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .spy_req(spy_req), .spy_wr(spy_wr), .spy_addr(spy_addr),
    .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .owner(owner),
    .loadmd(loadmd), .cpu_done(cpu_done), .spy_done(spy_done),
    .cpu_wait(cpu_wait), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one bus transaction in flight, one completion slot after it.
  typedef struct {
    bit                is_spy;
    bit                wr;
    logic [ADDR_W-1:0] addr;
    int                age;
  } xact_t;

  xact_t cur;
  bit    in_flight, done_slot, prev_req;
  int    starve;
  bit    e_loadmd, e_cpu_done, e_spy_done, e_mem_err;
  bit    dut_grants[$];

  task automatic model_reset();
    cur        = '{0, 0, '0, 0};
    in_flight  = 0;
    done_slot  = 0;
    prev_req   = 0;
    starve     = 0;
    e_loadmd   = 0;
    e_cpu_done = 0;
    e_spy_done = 0;
    e_mem_err  = 0;
  endtask

  task automatic model_finish(input bit err);
    in_flight  = 0;
    done_slot  = 1;
    e_cpu_done = !cur.is_spy;
    e_spy_done = cur.is_spy;
    e_loadmd   = !err && !cur.is_spy && !cur.wr;
    e_mem_err  = err;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    bit pick_spy;
    e_loadmd = 0; e_cpu_done = 0; e_spy_done = 0; e_mem_err = 0;
    if (done_slot) begin
      done_slot = 0;
    end else if (in_flight) begin
      cur.age++;
      if (mem_ack) model_finish(1'b0);
      else if (TO_EN && cur.age == int'(TIMEOUT)) model_finish(1'b1);
    end else if (cpu_req || spy_req) begin
      pick_spy = spy_req && (!cpu_req || starve >= int'(STARVE_MAX));
      if (pick_spy || !spy_req) starve = 0;
      else starve = (starve + 1 > int'(STARVE_MAX)) ? int'(STARVE_MAX) : starve + 1;
      cur.is_spy = pick_spy;
      cur.wr     = pick_spy ? spy_wr : cpu_wr;
      cur.addr   = pick_spy ? spy_addr : cpu_addr;
      cur.age    = 0;
      in_flight  = 1;
    end
  endtask

  // One clock: update model at the edge, compare every output #1 later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (mem_req && !prev_req) dut_grants.push_back(owner);
    prev_req = mem_req;
    check_eq("mem_req", 32'(mem_req), 32'(in_flight));
    if (in_flight) begin
      check_eq("mem_addr", 32'(mem_addr), 32'(cur.addr));
      check_eq("mem_wr", 32'(mem_wr), 32'(cur.wr));
    end
    if (in_flight || done_slot) check_eq("owner", 32'(owner), 32'(cur.is_spy));
    check_eq("loadmd", 32'(loadmd), 32'(e_loadmd));
    check_eq("cpu_done", 32'(cpu_done), 32'(e_cpu_done));
    check_eq("spy_done", 32'(spy_done), 32'(e_spy_done));
    check_eq("mem_err", 32'(mem_err), 32'(e_mem_err));
    check_eq("cpu_wait", 32'(cpu_wait), 32'(cpu_req & ~e_cpu_done));
  endtask

  task automatic drive_random_agents();
    if (cpu_req && e_cpu_done) begin
      if ($urandom_range(3) == 0) begin
        cpu_wr = 1'($urandom); cpu_addr = ADDR_W'($urandom);
      end else cpu_req = 1'b0;
    end else if (!cpu_req) begin
      if ($urandom_range(2) == 0) begin
        cpu_req = 1'b1; cpu_wr = 1'($urandom); cpu_addr = ADDR_W'($urandom);
      end
    end else if (in_flight && !cur.is_spy) begin
      cpu_wr = 1'($urandom); cpu_addr = ADDR_W'($urandom);
    end
    if (spy_req && e_spy_done) begin
      if ($urandom_range(3) == 0) begin
        spy_wr = 1'($urandom); spy_addr = ADDR_W'($urandom);
      end else spy_req = 1'b0;
    end else if (!spy_req) begin
      if ($urandom_range(3) == 0) begin
        spy_req = 1'b1; spy_wr = 1'($urandom); spy_addr = ADDR_W'($urandom);
      end
    end else if (in_flight && cur.is_spy) begin
      spy_wr = 1'($urandom); spy_addr = ADDR_W'($urandom);
    end
    mem_ack = ($urandom_range(2) == 0);
  endtask

  initial begin
    bit exp_order[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int guard;

    reset = 1'b0;
    cpu_req = 0; cpu_wr = 0; cpu_addr = '0;
    spy_req = 0; spy_wr = 0; spy_addr = '0;
    mem_ack = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    step();

    // Reset asserted in the middle of a CPU cycle.
    cpu_req = 1; cpu_wr = 0; cpu_addr = ADDR_W'($urandom);
    step();
    step();
    #2 reset = 1'b0;
    #1;
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_cpu_done", 32'(cpu_done), 32'd0);
    check_eq("rst_loadmd", 32'(loadmd), 32'd0);
    cpu_req = 0;
    @(negedge clk) reset = 1'b1;
    model_reset();
    step();

    // CPU read, ack three cycles after mem_req.
    cpu_req = 1; cpu_wr = 0; cpu_addr = 22'h012345;
    step();
    check_eq("rd_addr", 32'(mem_addr), 32'h012345);
    step();
    step();
    mem_ack = 1;
    step();
    check_eq("rd_loadmd", 32'(loadmd), 32'd1);
    check_eq("rd_cpu_wait", 32'(cpu_wait), 32'd0);
    cpu_req = 0; mem_ack = 0;
    step();
    check_eq("rd_loadmd_off", 32'(loadmd), 32'd0);

    // CPU write.
    cpu_req = 1; cpu_wr = 1; cpu_addr = ADDR_W'($urandom);
    step();
    mem_ack = 1;
    step();
    check_eq("wr_cpu_done", 32'(cpu_done), 32'd1);
    check_eq("wr_loadmd", 32'(loadmd), 32'd0);
    cpu_req = 0; mem_ack = 0;
    step();
    step();

    // Starvation: both held, immediate acks.
    dut_grants.delete();
    cpu_req = 1; cpu_wr = 0; spy_req = 1; spy_wr = 0; mem_ack = 1;
    guard = 0;
    while (dut_grants.size() < 10 && guard < 80) begin
      step();
      guard++;
    end
    check_eq("starve_grants", 32'(dut_grants.size()), 32'd10);
    for (int i = 0; i < 10 && i < dut_grants.size(); i++)
      check_eq($sformatf("starve_order[%0d]", i), 32'(dut_grants[i]), 32'(exp_order[i]));
    cpu_req = 0; spy_req = 0;
    repeat (4) step();
    mem_ack = 0;
    step();

    // Spy read in progress when the CPU requests.
    spy_req = 1; spy_wr = 0; spy_addr = ADDR_W'($urandom);
    step();
    cpu_req = 1; cpu_wr = 0; cpu_addr = ADDR_W'($urandom);
    step();
    check_eq("spy_cpu_wait", 32'(cpu_wait), 32'd1);
    step();
    mem_ack = 1;
    step();
    check_eq("spy_done", 32'(spy_done), 32'd1);
    check_eq("spy_loadmd", 32'(loadmd), 32'd0);
    spy_req = 0; mem_ack = 0;
    step();
    check_eq("spy_idle_noreq", 32'(mem_req), 32'd0);
    step();
    check_eq("cpu_after_spy", 32'(mem_req & ~owner), 32'd1);
    mem_ack = 1;
    step();
    cpu_req = 0; mem_ack = 0;
    step();
    step();

`ifdef MEM_TIMEOUT_EN
    // Timeout abort, then ack on the timeout edge.
    begin
      int n;
      cpu_req = 1; cpu_wr = 0; cpu_addr = ADDR_W'($urandom);
      step();
      n = 0;
      do begin step(); n++; end while (mem_req && n < 20);
      check_eq("to_cycles", 32'(n), 32'(TIMEOUT));
      check_eq("to_mem_err", 32'(mem_err), 32'd1);
      check_eq("to_loadmd", 32'(loadmd), 32'd0);
      cpu_req = 0;
      step();
      cpu_req = 1;
      step();
      repeat (TIMEOUT - 1) step();
      mem_ack = 1;
      step();
      check_eq("to_ack_loadmd", 32'(loadmd), 32'd1);
      check_eq("to_ack_err", 32'(mem_err), 32'd0);
      cpu_req = 0; mem_ack = 0;
      step();
      step();
    end
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step();
      drive_random_agents();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/md_mem_arbiter.md
Name: md_mem_arbiter

Overview:
- Sequences main-memory bus cycles that feed the memory data register.
- Arbitrates between two requesters: the CPU memory request path and the spy/debug port.
- Drives a single-outstanding mem_req/mem_ack handshake and returns completion to the winner.
- For CPU reads, generates the one-cycle loadmd strobe that captures bus data into MD.

Parameters:
ADDR_W, 22, width of the memory address.
STARVE_MAX, 4, consecutive CPU grants allowed while the spy is pending before the spy is forced through (range 1..15).
TIMEOUT, 255, cycles in CYCLE without mem_ack before abort. Only used with MEM_TIMEOUT_EN.

Ports:
clk  in  1  sole clock, rising edge.
reset  in  1  asynchronous, active-low reset.
cpu_req  in  1  CPU memory request, level; held until cpu_done.
cpu_wr  in  1  1 = CPU write cycle, 0 = read.
cpu_addr  in  ADDR_W  CPU address.
spy_req  in  1  spy request, level; held until spy_done.
spy_wr  in  1  1 = spy write.
spy_addr  in  ADDR_W  spy address.
mem_ack  in  1  bus completion from memory.
mem_req  out  1  bus request, registered.
mem_wr  out  1  bus write qualifier, registered.
mem_addr  out  ADDR_W  bus address, registered.
owner  out  1  0 = CPU, 1 = spy; valid while mem_req or DONE.
loadmd  out  1  one-cycle pulse: load MD from bus (CPU read only).
cpu_done  out  1  one-cycle completion pulse to CPU.
spy_done  out  1  one-cycle completion pulse to spy.
cpu_wait  out  1  CPU stall, combinational.
mem_err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (reset low, asynchronous):
  - State = IDLE, starve counter = 0, timeout counter = 0.
  - All registered outputs (mem_req, mem_wr, mem_addr, owner, loadmd, cpu_done, spy_done, mem_err) = 0.
  - Reset asserted mid-cycle drops mem_req immediately. No completion pulse is issued for the aborted cycle.
- States: IDLE, CYCLE, DONE. One bus cycle outstanding at most.
- IDLE, arbitration at each edge:
  - CPU wins if cpu_req and (not spy_req or starve < STARVE_MAX).
  - Otherwise the spy wins if spy_req.
  - On grant: latch addr/wr/owner into mem_addr/mem_wr/owner, set mem_req = 1, go to CYCLE. mem_req is visible the cycle after the request is seen.
- Starve counter:
  - Increments on a CPU grant made while spy_req = 1, saturating at STARVE_MAX.
  - Clears on any spy grant.
  - Clears when a CPU grant is made with spy_req = 0.
- CYCLE:
  - mem_req, mem_addr, mem_wr held stable.
  - When mem_ack is sampled high: mem_req cleared at that edge, go to DONE.
  - On that same edge, register the pulses:
    - loadmd = 1 iff owner = CPU and mem_wr = 0.
    - cpu_done = 1 iff owner = CPU.
    - spy_done = 1 iff owner = spy.
- DONE:
  - Pulses are high for exactly this one cycle.
  - Next edge: return to IDLE. No grant is made in DONE, so a requester has one cycle to drop its req.
  - A req still high in IDLE is a new request.
- mem_ack sampled in IDLE or DONE is ignored.
- Requester inputs (addr/wr) changing during CYCLE have no effect, because they are latched at grant.
- cpu_wait = cpu_req & ~cpu_done. It is high from request through the cycle before the DONE pulse, including while the spy owns the bus.
- Simultaneous cpu_req and spy_req with starve = STARVE_MAX: spy granted, counter cleared.
- Minimum back-to-back cycle time: 3 clocks (grant edge, ack edge, DONE).

Optional Feature:
MEM_TIMEOUT_EN:
- Defined:
  - An 8-bit (clog2(TIMEOUT+1)) counter counts clocks in CYCLE and clears on grant.
  - If it reaches TIMEOUT with no mem_ack, the cycle is aborted: mem_req cleared and state goes to DONE.
  - In DONE, mem_err = 1 and the owner's done pulse = 1; loadmd stays 0.
  - mem_ack on the same edge as the timeout wins: normal completion, no error.
- Undefined: no counter; CYCLE waits for mem_ack indefinitely; mem_err is tied 0.

Test Plan:
- Reset low mid-CYCLE with mem_req = 1 -> mem_req = 0 asynchronously, no done pulse; after release, state is IDLE and all outputs 0.
- CPU read, cpu_addr = 0x012345, ack 3 cycles after mem_req -> mem_addr = 0x012345, mem_wr = 0, owner = 0; loadmd = 1 and cpu_done = 1 for exactly one cycle; cpu_wait falls with cpu_done.
- CPU write -> cpu_done pulses, loadmd stays 0.
- cpu_req and spy_req held continuously with STARVE_MAX = 4, acks immediate -> grant order C,C,C,C,S,C,C,C,C,S; spy_done pulses only on S cycles.
- Spy read in progress when cpu_req rises -> cpu_wait = 1 throughout the spy cycle; CPU granted in the IDLE after spy DONE; loadmd = 0 on the spy completion.
- MEM_TIMEOUT_EN, TIMEOUT = 8, CPU read, no ack -> mem_req drops 8 cycles after the grant; mem_err = 1 and cpu_done = 1, loadmd = 0. Repeat with ack on cycle 8 -> loadmd = 1, mem_err = 0.
